// File: rtl/conv_job_sequencer_pkg.sv
// Shared definitions for the convolution job sequencer: FSM encoding and parameter defaults.
package conv_job_sequencer_pkg;

    localparam int ADDR_W_DEF        = 12;
    localparam int DATA_W_DEF        = 16;
    localparam int START_TIMEOUT_DEF = 16;
    localparam int BUSY_TIMEOUT_DEF  = 4096;
    localparam int TMR_W             = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_WAIT = 3'd2,
        S_READ = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/conv_job_sequencer_if.sv
// Bundle of job control, engine run/busy, output-SRAM read and result stream signals.
interface conv_job_sequencer_if
    import conv_job_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] num_out_rows;
    logic              dut_run;
    logic              dut_busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_addr;
    logic              job_busy;
    logic              job_done;
    logic              timeout_err;

    modport master (
        input  start, num_out_rows, dut_busy, rd_data, res_ready,
        output dut_run, rd_addr, res_valid, res_data, res_addr, job_busy, job_done, timeout_err
    );

    modport slave (
        output start, num_out_rows, dut_busy, rd_data, res_ready,
        input  dut_run, rd_addr, res_valid, res_data, res_addr, job_busy, job_done, timeout_err
    );
endinterface

// File: rtl/conv_job_sequencer_result_fifo2.sv
// Two-entry FIFO holding {addr, data} result words between the SRAM read and the consumer.
module result_fifo2 #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/conv_job_sequencer.sv
// Launches one engine job, waits for it to finish, then streams result rows from the output SRAM.
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | dut_run held until engine reports busy
//  WAIT  | engine computing; waiting for busy to drop
//  READ  | reading result rows out of SRAM to the consumer
//  DONE  | job_done pulse, success
//  ERR   | job_done pulse, start or busy timeout
module conv_job_sequencer
    import conv_job_sequencer_pkg::*;
#(
    parameter int                ADDR_W        = ADDR_W_DEF,
    parameter int                DATA_W        = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] OUT_BASE      = '0,
    parameter int                START_TIMEOUT = START_TIMEOUT_DEF,
    parameter int                BUSY_TIMEOUT  = BUSY_TIMEOUT_DEF
) (
    input logic                  clk,
    input logic                  reset,
    conv_job_sequencer_if.master bus
);
    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   timer;
    logic [ADDR_W-1:0]  count_q;
    logic [ADDR_W-1:0]  issue_idx;
    logic [ADDR_W-1:0]  delivered;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_addr;
    logic               timeout_err_q;
    logic [1:0]         fifo_cnt;
    logic [ADDR_W+DATA_W-1:0] head;
    logic               res_valid;
    logic               pop;
    logic               issue;
    logic [2:0]         occ_after;
    logic               run_o;
    logic               done_o;
    logic [ADDR_W-1:0]  rd_addr;

    assign res_valid = (fifo_cnt != 2'd0);
    assign pop       = res_valid & bus.res_ready;
    assign rd_addr   = (state == S_READ) ? (OUT_BASE + issue_idx) : '0;

    // Counting the word leaving this cycle lets a new read overlap the pop, giving 1 word/cycle.
    assign occ_after = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = (state == S_READ) && (issue_idx < count_q) && (occ_after < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_o     = 1'b0;
        done_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_RUN;
            end
            S_RUN: begin
                run_o = 1'b1;
                if (bus.dut_busy)         state_nxt = S_WAIT;
                else if (timer == '0)     state_nxt = S_ERR;
            end
            S_WAIT: begin
                if (!bus.dut_busy)        state_nxt = (count_q == '0) ? S_DONE : S_READ;
                else if (timer == '0)     state_nxt = S_ERR;
            end
            S_READ: begin
                if (pop && (delivered == count_q - 1'b1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer         <= '0;
            count_q       <= '0;
            issue_idx     <= '0;
            delivered     <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                timer         <= TMR_W'(START_TIMEOUT - 1);
                count_q       <= bus.num_out_rows;
                issue_idx     <= '0;
                delivered     <= '0;
                timeout_err_q <= 1'b0;
            end else begin
                if (state == S_RUN && state_nxt == S_WAIT) begin
                    timer <= TMR_W'(BUSY_TIMEOUT);
                end else if (timer != '0) begin
                    timer <= timer - 1'b1;
                end
                if (issue) issue_idx <= issue_idx + 1'b1;
                if (pop)   delivered <= delivered + 1'b1;
                if (state_nxt == S_ERR) timeout_err_q <= 1'b1;
            end
            inflight      <= issue;
            inflight_addr <= rd_addr;
        end
    end

    result_fifo2 #(.W(ADDR_W + DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   ({inflight_addr, bus.rd_data}),
        .dout  (head),
        .count (fifo_cnt)
    );

    assign bus.dut_run     = run_o;
    assign bus.job_done    = done_o;
    assign bus.job_busy    = (state != S_IDLE);
    assign bus.timeout_err = timeout_err_q;
    assign bus.rd_addr     = rd_addr;
    assign bus.res_valid   = res_valid;
    assign bus.res_addr    = head[ADDR_W+DATA_W-1:DATA_W];
    assign bus.res_data    = head[DATA_W-1:0];

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Randomized bench for conv_job_sequencer with a job-level reference model and result scoreboard.
module tb_conv_job_sequencer;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam logic [AW-1:0] BASE = 12'hFF0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_job_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    conv_job_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .OUT_BASE(BASE),
        .START_TIMEOUT(16), .BUSY_TIMEOUT(4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [4096];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    res_t exp_q[$];
    int   deliv_t[$];
    int   done_cnt, run_cycles, rd_changes, cyc;
    int   ready_mode;
    logic [AW-1:0] prev_rd;
    logic prev_stall;
    res_t prev_head;

    // consumer ready pattern: 0 always, 1 alternating, 2 random, other never
    initial begin
        logic tog;
        tog = 1'b0;
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            case (ready_mode)
                0:       bus.res_ready = 1'b1;
                1:       bus.res_ready = tog;
                2:       bus.res_ready = 1'($urandom_range(0, 1));
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    initial begin
        cyc = 0; prev_stall = 1'b0; prev_rd = '0; prev_head = '0;
        done_cnt = 0; run_cycles = 0; rd_changes = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.dut_run)  run_cycles++;
                if (bus.job_done) done_cnt++;
                if (bus.rd_addr != prev_rd) rd_changes++;
                if (prev_stall)
                    check_eq("stall_hold", 32'({bus.res_valid, bus.res_addr, bus.res_data}),
                             32'({1'b1, prev_head}));
                if (bus.res_valid && bus.res_ready) begin
                    check_eq("result_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        res_t e;
                        e = exp_q.pop_front();
                        check_eq("res_addr", 32'(bus.res_addr), 32'(e.addr));
                        check_eq("res_data", 32'(bus.res_data), 32'(e.data));
                    end
                    deliv_t.push_back(cyc);
                end
                prev_stall = bus.res_valid && !bus.res_ready;
                prev_head  = {bus.res_addr, bus.res_data};
            end
            prev_rd = bus.rd_addr;
        end
    end

    task automatic run_job(input int n, input int delay, input int len, input bit never,
                           input int mode, input bit poke_wait);
        bit seen;
        ready_mode = mode;
        exp_q.delete();
        deliv_t.delete();
        if (!never) begin
            for (int i = 0; i < n; i++) begin
                res_t r;
                r.addr = BASE + AW'(i);
                r.data = mem[r.addr];
                exp_q.push_back(r);
            end
        end
        @(posedge clk); #1;
        done_cnt = 0; run_cycles = 0; rd_changes = 0;
        bus.start = 1'b1;
        bus.num_out_rows = AW'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.num_out_rows = AW'($urandom);
        @(negedge clk);
        check_eq("job_busy_after_start", 32'(bus.job_busy), 32'd1);
        check_eq("terr_cleared", 32'(bus.timeout_err), 32'd0);
        if (!never) begin
            repeat (delay) @(posedge clk);
            #1 bus.dut_busy = 1'b1;
            if (poke_wait) begin
                repeat (2) @(posedge clk);
                #1 bus.start = 1'b1; bus.num_out_rows = AW'(5);
                @(posedge clk);
                #1 bus.start = 1'b0;
                repeat (len - 3) @(posedge clk);
            end else begin
                repeat (len) @(posedge clk);
            end
            #1 bus.dut_busy = 1'b0;
        end
        seen = 1'b0;
        for (int g = 0; g < 20000 && !seen; g++) begin
            @(negedge clk);
            if (bus.job_done) seen = 1'b1;
        end
        check_eq("job_done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_eq("busy_at_done", 32'(bus.job_busy), 32'd1);
            @(negedge clk);
            check_eq("busy_after_done", 32'(bus.job_busy), 32'd0);
            check_eq("done_single", 32'(bus.job_done), 32'd0);
        end
        repeat (3) @(negedge clk);
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("timeout_err", 32'(bus.timeout_err), 32'(never));
        check_eq("run_cycles", 32'(run_cycles), never ? 32'd16 : 32'(delay + 1));
        check_eq("missing_results", 32'(exp_q.size()), 32'd0);
        check_eq("job_busy_idle", 32'(bus.job_busy), 32'd0);
        if (never) check_eq("rd_addr_quiet", 32'(rd_changes), 32'd0);
        if (mode == 0 && n > 0 && !never) begin
            check_eq("deliv_count", 32'(deliv_t.size()), 32'(n));
            if (deliv_t.size() > 0)
                check_eq("deliv_back_to_back", 32'(deliv_t[$] - deliv_t[0]), 32'(n - 1));
        end
    endtask

    task automatic reset_mid_read();
        bit seen;
        ready_mode = 3;
        exp_q.delete();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_out_rows = AW'(6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.dut_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.dut_busy = 1'b0;
        seen = 1'b0;
        for (int g = 0; g < 50 && !seen; g++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        check_eq("valid_before_reset", 32'(seen), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("reset_clears_valid", 32'(bus.res_valid), 32'd0);
        check_eq("reset_clears_busy", 32'(bus.job_busy), 32'd0);
        check_eq("reset_clears_run", 32'(bus.dut_run), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.num_out_rows = '0;
        bus.dut_busy = 1'b0;
        ready_mode = 0;
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_dut_run", 32'(bus.dut_run), 32'd0);
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_job_busy", 32'(bus.job_busy), 32'd0);
        check_eq("rst_job_done", 32'(bus.job_done), 32'd0);
        check_eq("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        check_eq("rst_result_bus", 32'({bus.rd_addr, bus.res_addr, bus.res_data} != '0), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        run_job(3, 4, 10, 1'b0, 0, 1'b0);
        run_job(3, 2, 10, 1'b0, 1, 1'b0);
        run_job(3, 0, 0, 1'b1, 0, 1'b0);
        run_job(0, 3, 5, 1'b0, 0, 1'b0);
        reset_mid_read();
        run_job(4, 1, 6, 1'b0, 2, 1'b0);
        run_job(3, 2, 8, 1'b0, 0, 1'b1);
        run_job(2, 15, 4, 1'b0, 0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            run_job($urandom_range(1, 20), $urandom_range(0, 12), $urandom_range(1, 30),
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 2), 1'b0);
        end
        run_job(4095, 1, 3, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
